// File: rtl/seg7_capture_if.sv
// Bundle of the segment-capture bus and the decoded-result handshake.
// The slave modport is the decoder side; the master modport is the driver/consumer side.
interface seg7_capture_if #(
  parameter int unsigned ERR_CNT_W = 8
) ();
  logic [6:0]           seg_in;
  logic                 out_ready;
  logic                 out_valid;
  logic [3:0]           out_digit;
  logic                 out_blank;
  logic                 out_err;
  logic                 overrun;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output seg_in, out_ready,
    input  out_valid, out_digit, out_blank, out_err, overrun, err_count
  );

  modport slave (
    input  seg_in, out_ready,
    output out_valid, out_digit, out_blank, out_err, overrun, err_count
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Captures an asynchronous active-low 7-segment bus, waits for stability and decodes it back to
// a digit behind a valid/ready handshake. Define SEG7_HEX_EN to also decode the A..F glyphs.
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input logic            clk,
  input logic            rst,
  seg7_capture_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [6:0] SegBlank = 7'h7f;

  logic [6:0]           s1_q, s2_q, s3_q;
  logic [2:0]           fill_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [6:0]           last_q;
  logic                 last_vld_q;
  logic                 valid_q, valid_d;
  logic [3:0]           digit_q, digit_d;
  logic                 blank_q, blank_d;
  logic                 err_q, err_d;
  logic                 ovr_q, ovr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 accept;
  logic [3:0]           dec_digit;
  logic                 dec_blank;
  logic                 dec_err;

  // s3 is the sample the stability counter describes; fill_q marks which stages hold real data
  // so that counting starts only once the first post-reset sample reaches s2.
  always_comb begin
    cnt_d = cnt_q;
    if (!fill_q[1]) begin
      cnt_d = '0;
    end else if (!fill_q[2] || (s2_q != s3_q)) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign accept = (cnt_q == CntMax) && (!last_vld_q || (s3_q != last_q));

  // Pattern bits are index 6 (g) down to index 0 (a), active-low.
  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (s3_q)
      7'b1000000: dec_digit = 4'd0;
      7'b1111001: dec_digit = 4'd1;
      7'b0100100: dec_digit = 4'd2;
      7'b0110000: dec_digit = 4'd3;
      7'b0011001: dec_digit = 4'd4;
      7'b0010010: dec_digit = 4'd5;
      7'b0000010: dec_digit = 4'd6;
      7'b1011000: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0010000: dec_digit = 4'd9;
`ifdef SEG7_HEX_EN
      7'b0001000: dec_digit = 4'd10;
      7'b0000011: dec_digit = 4'd11;
      7'b1000110: dec_digit = 4'd12;
      7'b0100001: dec_digit = 4'd13;
      7'b0000110: dec_digit = 4'd14;
      7'b0001110: dec_digit = 4'd15;
`else
`endif
      SegBlank:   dec_blank = 1'b1;
      default:    dec_err   = 1'b1;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    digit_d   = digit_q;
    blank_d   = blank_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (dec_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (valid_q && !bus.out_ready) begin
        // Consumer still holds the old result: drop the new one.
        ovr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        digit_d = dec_digit;
        blank_d = dec_blank;
        err_d   = dec_err;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= SegBlank;
      s2_q       <= SegBlank;
      s3_q       <= SegBlank;
      fill_q     <= '0;
      cnt_q      <= '0;
      last_q     <= SegBlank;
      last_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      digit_q    <= 4'd0;
      blank_q    <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_q      <= bus.seg_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      fill_q    <= {fill_q[1:0], 1'b1};
      cnt_q     <= cnt_d;
      if (accept) begin
        last_q     <= s3_q;
        last_vld_q <= 1'b1;
      end
      valid_q   <= valid_d;
      digit_q   <= digit_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_digit = digit_q;
  assign bus.out_blank = blank_q;
  assign bus.out_err   = err_q;
  assign bus.overrun   = ovr_q;
  assign bus.err_count = err_cnt_q;

endmodule
